// File: rtl/ahb_master_if.sv
// Bundle of command-side and AHB-Lite bus signals for ahb_master.
// The master modport is the ahb_master side; the slave modport is the controller/bus side.
interface ahb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        cmd_size;
  logic [4:0]        cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_pop;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              done;
  logic              cmd_err;
  logic [ADDR_W-1:0] HADDR;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [1:0]        HTRANS;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic [DATA_W-1:0] HRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_len, wr_data, HREADY, HRDATA,
    output cmd_ready, wr_pop, rd_data, rd_valid, done, cmd_err,
           HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_len, wr_data, HREADY, HRDATA,
    input  cmd_ready, wr_pop, rd_data, rd_valid, done, cmd_err,
           HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA
  );
endinterface

// File: rtl/ahb_master.sv
// Single-outstanding AHB-Lite master: one command becomes a SINGLE/INCR burst with overlapped phases.
// Optional 1 KB boundary rejection is enabled by defining AHB_MASTER_1KB_CHECK_EN.
module ahb_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  ahb_master_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t            r_state;
  logic [4:0]        r_beats_left;
  logic              r_dphase;
  logic              r_cmd_ready;
  logic [ADDR_W-1:0] r_haddr;
  logic              r_hwrite;
  logic [2:0]        r_hsize;
  logic [2:0]        r_hburst;
  logic [1:0]        r_htrans;
  logic [DATA_W-1:0] r_hwdata;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_done;

  logic [2:0]        w_size_eff;
  logic [4:0]        w_len_eff;
  logic [2:0]        w_burst;
  logic              w_accept;

  assign w_size_eff = (bus.cmd_size > 3'd2) ? 3'd2 : bus.cmd_size;
  assign w_len_eff  = (bus.cmd_len == 5'd0) ? 5'd1 : bus.cmd_len;
  assign w_accept   = (r_state == S_ADDR) && bus.HREADY;

  always_comb begin
    case (w_len_eff)
      5'd1:    w_burst = 3'b000;
      5'd4:    w_burst = 3'b011;
      5'd8:    w_burst = 3'b101;
      5'd16:   w_burst = 3'b111;
      default: w_burst = 3'b001;
    endcase
  end

`ifdef AHB_MASTER_1KB_CHECK_EN
  logic [11:0] w_span;
  logic [11:0] w_end;
  logic        w_reject;
  logic        r_cmd_err;

  // Burst end offset within its 1 KB page; landing exactly on 0x400 is still legal.
  assign w_span    = 12'(w_len_eff) << w_size_eff;
  assign w_end     = {2'b00, bus.cmd_addr[9:0]} + w_span;
  assign w_reject  = (w_end > 12'h400);
  assign bus.cmd_err = r_cmd_err;
`else
  assign bus.cmd_err = 1'b0;
`endif

  // The pop must coincide with the accepting edge, so it cannot be registered.
  assign bus.wr_pop   = w_accept && r_hwrite;
  assign bus.cmd_ready = r_cmd_ready;
  assign bus.HADDR    = r_haddr;
  assign bus.HWRITE   = r_hwrite;
  assign bus.HSIZE    = r_hsize;
  assign bus.HBURST   = r_hburst;
  assign bus.HTRANS   = r_htrans;
  assign bus.HWDATA   = r_hwdata;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.done     = r_done;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state      <= S_IDLE;
      r_beats_left <= 5'd0;
      r_dphase     <= 1'b0;
      r_cmd_ready  <= 1'b1;
      r_haddr      <= '0;
      r_hwrite     <= 1'b0;
      r_hsize      <= 3'd0;
      r_hburst     <= 3'd0;
      r_htrans     <= 2'b00;
      r_hwdata     <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_done       <= 1'b0;
`ifdef AHB_MASTER_1KB_CHECK_EN
      r_cmd_err    <= 1'b0;
`endif
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
`ifdef AHB_MASTER_1KB_CHECK_EN
      r_cmd_err  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
`ifdef AHB_MASTER_1KB_CHECK_EN
            if (w_reject)
              r_cmd_err <= 1'b1;
            else
`endif
            begin
              r_haddr      <= bus.cmd_addr;
              r_hwrite     <= bus.cmd_write;
              r_hsize      <= w_size_eff;
              r_hburst     <= w_burst;
              r_htrans     <= 2'b10;
              r_beats_left <= w_len_eff;
              r_dphase     <= 1'b0;
              r_cmd_ready  <= 1'b0;
              r_state      <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (bus.HREADY) begin
            r_haddr      <= r_haddr + (ADDR_W'(1) << r_hsize);
            r_beats_left <= r_beats_left - 5'd1;
            r_dphase     <= 1'b1;
            if (r_hwrite)
              r_hwdata <= bus.wr_data;
            // Previous beat's data phase completes on this same edge.
            if (r_dphase && !r_hwrite) begin
              r_rd_valid <= 1'b1;
              r_rd_data  <= bus.HRDATA;
            end
            if (r_beats_left == 5'd1) begin
              r_htrans <= 2'b00;
              r_state  <= S_DATA;
            end else begin
              r_htrans <= 2'b11;
            end
          end
        end
        S_DATA: begin
          if (bus.HREADY) begin
            if (!r_hwrite) begin
              r_rd_valid <= 1'b1;
              r_rd_data  <= bus.HRDATA;
            end
            r_done      <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_dphase    <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master.sv
// Self-checking bench for ahb_master: command table plus scoreboard queues for address, write and read beats.
// Honours AHB_MASTER_1KB_CHECK_EN when deciding which commands must be rejected.
`timescale 1ns/1ps
module tb_ahb_master;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef AHB_MASTER_1KB_CHECK_EN
  localparam logic KB_EN = 1'b1;
`else
  localparam logic KB_EN = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [4:0]  len;
    int          stall_off;
    int          stall_len;
    logic [2:0]  exp_burst;
    logic        crosses_1kb;
  } vec_t;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ahb_master #(.ADDR_W(AW), .DATA_W(DW)) dut (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  logic [40:0] addr_q[$];
  logic [31:0] wdata_q[$];
  logic [31:0] rd_q[$];

  logic [31:0] wr_vals[256];
  logic [7:0]  pop_cnt = 8'd0;
  logic [31:0] rd_base = 32'd0;
  logic        dp_valid;
  logic [31:0] dp_idx;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Caller write FIFO: head advances on every pop
  assign bus.wr_data = wr_vals[pop_cnt];
  always @(posedge HCLK)
    if (bus.wr_pop) pop_cnt <= pop_cnt + 8'd1;

  // Slave model: read data = burst-relative beat number + 1 + rd_base
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_idx   <= 32'd0;
    end else if (bus.HREADY) begin
      dp_valid <= bus.HTRANS[1];
      if (bus.HTRANS == 2'b10)      dp_idx <= 32'd0;
      else if (bus.HTRANS == 2'b11) dp_idx <= dp_idx + 32'd1;
    end
  end
  assign bus.HRDATA = dp_valid ? (rd_base + dp_idx + 32'd1) : 32'd0;

  // Bus monitor
  logic         prev_pop = 1'b0;
  logic         prev_hready = 1'b1;
  logic         prev_valid = 1'b0;
  logic [127:0] prev_snap = '0;
  logic [127:0] snap_now;
  assign snap_now = {54'd0, bus.HADDR, bus.HTRANS, bus.HWRITE, bus.HSIZE, bus.HBURST, bus.HWDATA, bus.cmd_ready};

  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (bus.HTRANS[1] && bus.HREADY) begin
        if (addr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_addr_phase: got HADDR %0h HTRANS %0b, required none", bus.HADDR, bus.HTRANS);
        end else
          chk("addr_phase", {bus.HADDR, bus.HTRANS, bus.HBURST, bus.HWRITE, bus.HSIZE}, addr_q.pop_front());
      end
      if (prev_pop) begin
        if (wdata_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_wr_pop: got HWDATA %0h, required no pop", bus.HWDATA);
        end else
          chk("hwdata", bus.HWDATA, wdata_q.pop_front());
      end
      if (bus.rd_valid) begin
        if (rd_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_rd_valid: got rd_data %0h, required none", bus.rd_data);
        end else
          chk("rd_data", bus.rd_data, rd_q.pop_front());
      end
      if (!bus.HREADY) chk("wr_pop_in_wait", bus.wr_pop, 1'b0);
      if (prev_valid && !prev_hready) begin
        chk("freeze_outputs", snap_now, prev_snap);
        chk("no_pulse_after_wait", {bus.done, bus.rd_valid}, 2'b00);
      end
      prev_pop    <= bus.wr_pop;
      prev_hready <= bus.HREADY;
      prev_snap   <= snap_now;
      prev_valid  <= 1'b1;
    end else begin
      prev_pop   <= 1'b0;
      prev_valid <= 1'b0;
    end
  end

  task automatic run_cmd(input vec_t v, input logic [31:0] rbase);
    int n, sz, cyc, done_k, done_n, err_n;
    logic exp_err;
    logic [7:0] pop0;
    logic [31:0] a;
    n  = (v.len == 5'd0) ? 1 : int'(v.len);
    sz = (v.size > 3'd2) ? 2 : int'(v.size);
    exp_err = v.crosses_1kb & KB_EN;
    cyc = 0;
    while (!bus.cmd_ready && cyc < 50) begin
      @(posedge HCLK); #1; cyc++;
    end
    chk("cmd_ready_wait", bus.cmd_ready, 1'b1);
    rd_base = rbase;
    pop0 = pop_cnt;
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        a = v.addr + (32'(i) << sz);
        addr_q.push_back({a, (i == 0) ? 2'b10 : 2'b11, v.exp_burst, v.wr, 3'(sz)});
        if (v.wr) wdata_q.push_back(wr_vals[8'(pop0 + 8'(i))]);
        else      rd_q.push_back(rbase + 32'(i) + 32'd1);
      end
    end
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_size  = v.size;
    bus.cmd_len   = v.len;
    bus.cmd_valid = 1'b1;
    @(posedge HCLK); #1;
    bus.cmd_valid = 1'b0;
    done_k = 0; done_n = 0; err_n = 0;
    for (int k = 1; k <= n + 4 + v.stall_len; k++) begin
      bus.HREADY = !(v.stall_len > 0 && k >= v.stall_off && k < v.stall_off + v.stall_len);
      @(negedge HCLK);
      if (k == 1) begin
        chk("first_htrans", bus.HTRANS, exp_err ? 2'b00 : 2'b10);
        chk("cmd_ready_after_accept", bus.cmd_ready, exp_err);
        chk("cmd_err_pulse", bus.cmd_err, exp_err);
      end else if (bus.cmd_err) err_n++;
      if (bus.done) begin
        done_n++;
        if (done_k == 0) begin
          done_k = k;
          chk("cmd_ready_at_done", bus.cmd_ready, 1'b1);
        end
      end
      @(posedge HCLK); #1;
    end
    bus.HREADY = 1'b1;
    chk("extra_cmd_err", err_n, 0);
    chk("done_count", done_n, exp_err ? 0 : 1);
    if (!exp_err) chk("done_cycle", done_k, n + 2 + v.stall_len);
    chk("pop_count", 8'(pop_cnt - pop0), (v.wr && !exp_err) ? n : 0);
    chk("queues_drained", addr_q.size() + wdata_q.size() + rd_q.size(), 0);
    $display("cmd wr=%0b addr=%08h size=%0d len=%0d done_cycle=%0d", v.wr, v.addr, v.size, v.len, done_k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) wr_vals[i] = 32'hA5000000 ^ (32'(i) * 32'h00010203);
    wr_vals[0] = 32'hDEADBEEF;

    vecs[0] = '{wr:1'b1, addr:32'h00000100, size:3'd2, len:5'd1,  stall_off:0, stall_len:0, exp_burst:3'b000, crosses_1kb:1'b0};
    vecs[1] = '{wr:1'b0, addr:32'h00000200, size:3'd2, len:5'd4,  stall_off:0, stall_len:0, exp_burst:3'b011, crosses_1kb:1'b0};
    vecs[2] = '{wr:1'b1, addr:32'h00000400, size:3'd2, len:5'd8,  stall_off:3, stall_len:2, exp_burst:3'b101, crosses_1kb:1'b0};
    vecs[3] = '{wr:1'b0, addr:32'hFFFFFFFC, size:3'd1, len:5'd3,  stall_off:0, stall_len:0, exp_burst:3'b001, crosses_1kb:1'b1};
    vecs[4] = '{wr:1'b1, addr:32'h00001000, size:3'd0, len:5'd16, stall_off:5, stall_len:1, exp_burst:3'b111, crosses_1kb:1'b0};
    vecs[5] = '{wr:1'b0, addr:32'h00002000, size:3'd5, len:5'd0,  stall_off:0, stall_len:0, exp_burst:3'b000, crosses_1kb:1'b0};
    vecs[6] = '{wr:1'b1, addr:32'h000003F8, size:3'd2, len:5'd4,  stall_off:0, stall_len:0, exp_burst:3'b011, crosses_1kb:1'b1};
    vecs[7] = '{wr:1'b0, addr:32'h00000080, size:3'd2, len:5'd2,  stall_off:2, stall_len:3, exp_burst:3'b001, crosses_1kb:1'b0};
    vecs[8] = '{wr:1'b1, addr:32'h000003F0, size:3'd2, len:5'd4,  stall_off:0, stall_len:0, exp_burst:3'b011, crosses_1kb:1'b0};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'd0;
    bus.cmd_size  = 3'd0;
    bus.cmd_len   = 5'd0;
    bus.HREADY    = 1'b1;

    #12;
    chk("rst_htrans",    bus.HTRANS, 2'b00);
    chk("rst_haddr",     bus.HADDR, 32'd0);
    chk("rst_hctrl",     {bus.HWRITE, bus.HSIZE, bus.HBURST}, 7'd0);
    chk("rst_hwdata",    bus.HWDATA, 32'd0);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_pulses",    {bus.wr_pop, bus.rd_valid, bus.done, bus.cmd_err}, 4'd0);
    chk("rst_rd_data",   bus.rd_data, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    for (int i = 0; i < 9; i++)
      run_cmd(vecs[i], (i == 1) ? 32'd0 : (32'(i) << 16));

    // Reset in the middle of an INCR16 read
    for (int i = 0; i < 16; i++) begin
      addr_q.push_back({32'h00003000 + (32'(i) << 2), (i == 0) ? 2'b10 : 2'b11, 3'b111, 1'b0, 3'd2});
      rd_q.push_back(32'h00F00000 + 32'(i) + 32'd1);
    end
    rd_base = 32'h00F00000;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h00003000;
    bus.cmd_size  = 3'd2;
    bus.cmd_len   = 5'd16;
    bus.cmd_valid = 1'b1;
    @(posedge HCLK); #1;
    bus.cmd_valid = 1'b0;
    repeat (6) @(posedge HCLK);
    #3;
    HRESETn = 1'b0;
    #1;
    chk("async_rst_htrans",    bus.HTRANS, 2'b00);
    chk("async_rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("async_rst_haddr",     bus.HADDR, 32'd0);
    chk("async_rst_pulses",    {bus.done, bus.rd_valid, bus.wr_pop}, 3'd0);
    addr_q.delete();
    rd_q.delete();
    wdata_q.delete();
    repeat (2) begin
      @(negedge HCLK);
      chk("no_done_in_reset", bus.done, 1'b0);
    end
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    $display("reset applied mid-INCR16, restarting");
    run_cmd(vecs[1], 32'h77000000);
    run_cmd(vecs[0], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
